// File: rtl/adc_sample_feeder.sv
// ADC sample feeder: buffers tagged samples, converts them to single precision and drives one
// multiply-add transaction at a time, forwarding each result with its channel tag.
module adc_sample_feeder #(
  parameter int unsigned ADC_WIDTH  = 12,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADC_WIDTH-1:0] adc_sample,
  input  logic [1:0]           adc_channel,
  input  logic                 adc_valid,
  input  logic                 coef_wr_en,
  input  logic                 coef_sel,
  input  logic [1:0]           coef_ch,
  input  logic [31:0]          coef_data,
  output logic [31:0]          ma_data_in_1,
  output logic [31:0]          ma_data_in_2,
  output logic [31:0]          ma_data_in_3,
  output logic                 ma_data_in_ready,
  input  logic [31:0]          ma_data_out,
  input  logic                 ma_data_out_ready,
  output logic [31:0]          corr_data,
  output logic [1:0]           corr_channel,
  output logic                 corr_valid,
  output logic                 fifo_full,
  output logic                 overflow,
  output logic                 timeout_err,
  output logic [1:0]           state
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EntW = ADC_WIDTH + 2;
  localparam int unsigned TmoW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);
  localparam logic [TmoW-1:0] TmoLast   = TmoW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle = 2'd0, StWait = 2'd1, StDone = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [EntW-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     gain_q [4];
  logic [31:0]     offset_q [4];
  logic [TmoW-1:0] wait_cnt_q;
  logic [1:0]      tag_q;
  logic            full, push, issue, accept, abandon;
  logic [EntW-1:0] head;
  logic [1:0]      head_ch;

  // Exact for ADC_WIDTH <= 24: the leading one lands on the hidden bit with no bits lost.
  function automatic logic [31:0] to_float(input logic [ADC_WIDTH-1:0] s);
    int unsigned p;
    logic [23:0] ext;
    logic [22:0] man;
    p = 0;
    for (int i = 0; i < ADC_WIDTH; i++) begin
      if (s[i]) p = i;
    end
    ext = 24'(s);
    man = 23'(ext << (23 - p));
    if (s == '0) return 32'h0;
    return {1'b0, 8'(127 + p), man};
  endfunction

  assign head    = fifo_mem_q[rd_ptr_q];
  assign head_ch = head[EntW-1 -: 2];
  assign full    = (count_q == FullCount);
  assign push    = adc_valid && !full;
  assign state   = state_q;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (count_q != '0) state_d = StWait;
      StWait: begin
        if (ma_data_out_ready)         state_d = StDone;
        else if (wait_cnt_q == TmoLast) state_d = StIdle;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    issue   = (state_q == StIdle) && (count_q != '0);
    accept  = (state_q == StWait) && ma_data_out_ready;
    abandon = (state_q == StWait) && !ma_data_out_ready && (wait_cnt_q == TmoLast);
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, issue})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {adc_channel, adc_sample};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      fifo_full        <= 1'b0;
      overflow         <= 1'b0;
      timeout_err      <= 1'b0;
      wait_cnt_q       <= '0;
      tag_q            <= '0;
      ma_data_in_1     <= '0;
      ma_data_in_2     <= '0;
      ma_data_in_3     <= '0;
      ma_data_in_ready <= 1'b0;
      corr_data        <= '0;
      corr_channel     <= '0;
      corr_valid       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        gain_q[i]   <= 32'h3F80_0000;
        offset_q[i] <= 32'h0000_0000;
      end
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (issue) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q     <= count_d;
      fifo_full   <= (count_d == FullCount);
      overflow    <= overflow | (adc_valid & full);
      timeout_err <= timeout_err | abandon;

      if (coef_wr_en) begin
        if (coef_sel) offset_q[coef_ch] <= coef_data;
        else          gain_q[coef_ch]   <= coef_data;
      end

      ma_data_in_ready <= issue;
      if (issue) begin
        ma_data_in_1 <= to_float(head[ADC_WIDTH-1:0]);
        ma_data_in_2 <= gain_q[head_ch];
        ma_data_in_3 <= offset_q[head_ch];
        tag_q        <= head_ch;
        wait_cnt_q   <= '0;
      end else if (state_q == StWait && !ma_data_out_ready && !abandon) begin
        wait_cnt_q <= wait_cnt_q + TmoW'(1);
      end

      corr_valid <= accept;
      if (accept) begin
        corr_data    <= ma_data_out;
        corr_channel <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_feeder.sv
// Bench for adc_sample_feeder: directed scenarios plus randomized transactions against a
// behavioural model of conversion and coefficient storage.
module tb_adc_sample_feeder;

  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] adc_sample;
  logic [1:0]    adc_channel;
  logic          adc_valid;
  logic          coef_wr_en;
  logic          coef_sel;
  logic [1:0]    coef_ch;
  logic [31:0]   coef_data;
  logic [31:0]   ma_data_in_1, ma_data_in_2, ma_data_in_3;
  logic          ma_data_in_ready;
  logic [31:0]   ma_data_out;
  logic          ma_data_out_ready;
  logic [31:0]   corr_data;
  logic [1:0]    corr_channel;
  logic          corr_valid;
  logic          fifo_full, overflow, timeout_err;
  logic [1:0]    state;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] m_gain [4];
  logic [31:0] m_off  [4];

  adc_sample_feeder #(.ADC_WIDTH(AW), .FIFO_DEPTH(4), .TIMEOUT(1023)) dut (
    .clk(clk), .reset(reset), .adc_sample(adc_sample), .adc_channel(adc_channel),
    .adc_valid(adc_valid), .coef_wr_en(coef_wr_en), .coef_sel(coef_sel), .coef_ch(coef_ch),
    .coef_data(coef_data), .ma_data_in_1(ma_data_in_1), .ma_data_in_2(ma_data_in_2),
    .ma_data_in_3(ma_data_in_3), .ma_data_in_ready(ma_data_in_ready),
    .ma_data_out(ma_data_out), .ma_data_out_ready(ma_data_out_ready), .corr_data(corr_data),
    .corr_channel(corr_channel), .corr_valid(corr_valid), .fifo_full(fifo_full),
    .overflow(overflow), .timeout_err(timeout_err), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Value of s as a float: s = 2^e * (1 + frac), frac scaled to 23 bits.
  function automatic logic [31:0] ref_float(input int unsigned s);
    longint unsigned pw, m;
    int unsigned e;
    if (s == 0) return 32'h0;
    pw = 1;
    e  = 0;
    while (pw * 2 <= longint'(s)) begin
      pw = pw * 2;
      e++;
    end
    m = longint'(s) - pw;
    for (int k = int'(e); k < 23; k++) m = m * 2;
    return {1'b0, 8'(127 + e), 23'(m)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_gain[i] = 32'h3F80_0000;
      m_off[i]  = 32'h0;
    end
  endtask

  task automatic write_coef(input logic sel, input logic [1:0] ch, input logic [31:0] d);
    coef_wr_en = 1'b1;
    coef_sel   = sel;
    coef_ch    = ch;
    coef_data  = d;
    tick();
    coef_wr_en = 1'b0;
    if (sel) m_off[ch] = d;
    else     m_gain[ch] = d;
  endtask

  task automatic pulse_result(input logic [31:0] ret, input logic [1:0] ch);
    ma_data_out       = ret;
    ma_data_out_ready = 1'b1;
    tick();
    ma_data_out_ready = 1'b0;
    chk("corr_valid_hi", corr_valid, 1);
    chk("corr_data", corr_data, ret);
    chk("corr_channel", corr_channel, ch);
    chk("state_done", state, 2);
    tick();
    chk("corr_valid_1cyc", corr_valid, 0);
    chk("state_idle", state, 0);
  endtask

  // Single sample into an empty FIFO with the FSM idle: issue at E+1, result after dly.
  task automatic run_txn(input logic [1:0] ch, input int unsigned s, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3, input logic [31:0] ret,
                         input int unsigned dly);
    adc_sample  = AW'(s);
    adc_channel = ch;
    adc_valid   = 1'b1;
    tick();
    adc_valid = 1'b0;
    chk("ready_not_at_E", ma_data_in_ready, 0);
    tick();
    chk("ready_at_E1", ma_data_in_ready, 1);
    chk("ma_in_1", ma_data_in_1, e1);
    chk("ma_in_2", ma_data_in_2, e2);
    chk("ma_in_3", ma_data_in_3, e3);
    chk("state_wait", state, 1);
    tick();
    chk("ready_1cyc", ma_data_in_ready, 0);
    repeat (dly) tick();
    pulse_result(ret, ch);
  endtask

  task automatic wait_issue();
    int n;
    n = 0;
    while (!ma_data_in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("issue_seen", ma_data_in_ready, 1);
  endtask

  initial begin
    logic [1:0]  ch;
    int unsigned s;
    logic [31:0] ret;
    logic        saw_valid;

    reset = 1'b0; adc_sample = '0; adc_channel = '0; adc_valid = 1'b0;
    coef_wr_en = 1'b0; coef_sel = 1'b0; coef_ch = '0; coef_data = '0;
    ma_data_out = '0; ma_data_out_ready = 1'b0;
    model_reset();
    tick(); tick();
    reset = 1'b1;
    chk("rst_in_ready", ma_data_in_ready, 0);
    chk("rst_in_1", ma_data_in_1, 0);
    chk("rst_corr_valid", corr_valid, 0);
    chk("rst_fifo_full", fifo_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_state", state, 0);

    run_txn(2'd0, 1,    32'h3F80_0000, 32'h3F80_0000, 32'h0, 32'h1111_1111, 0);
    run_txn(2'd0, 2048, 32'h4500_0000, 32'h3F80_0000, 32'h0, 32'h2222_2222, 1);
    run_txn(2'd0, 4095, 32'h457F_F000, 32'h3F80_0000, 32'h0, 32'h3333_3333, 2);
    run_txn(2'd0, 0,    32'h0000_0000, 32'h3F80_0000, 32'h0, 32'h4444_4444, 0);

    write_coef(1'b0, 2'd2, 32'h4000_0000);
    write_coef(1'b1, 2'd2, 32'h3F80_0000);
    run_txn(2'd2, 3, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000, 32'h40E0_0000, 3);

    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 1) == 1)
        write_coef(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
      ch  = 2'($urandom_range(0, 3));
      s   = $urandom_range(0, (1 << AW) - 1);
      ret = $urandom;
      run_txn(ch, s, ref_float(s), m_gain[ch], m_off[ch], ret, $urandom_range(0, 4));
    end

    // Burst of six with results stalled: one in flight, four buffered, one dropped.
    for (int i = 0; i < 6; i++) begin
      adc_sample  = AW'(10 + i);
      adc_channel = 2'd1;
      adc_valid   = 1'b1;
      tick();
      if (i == 4) begin
        chk("full_after_4", fifo_full, 1);
        chk("no_ovf_before_6th", overflow, 0);
      end
    end
    adc_valid = 1'b0;
    chk("burst_full", fifo_full, 1);
    chk("burst_overflow", overflow, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) wait_issue();
      chk("burst_order", ma_data_in_1, ref_float(10 + i));
      chk("burst_gain", ma_data_in_2, m_gain[1]);
      pulse_result($urandom, 2'd1);
      if (i == 0) begin
        // Push while full on the same edge as a pop must still be dropped.
        adc_sample = AW'(99);
        adc_valid  = 1'b1;
        tick();
        adc_valid = 1'b0;
        chk("pop_full_not_full", fifo_full, 0);
        chk("pop_full_issue", ma_data_in_ready, 1);
      end
    end
    repeat (3) tick();
    chk("dropped_not_issued", ma_data_in_ready, 0);
    chk("drained_idle", state, 0);

    // Timeout: A stalls, B queued behind it.
    adc_channel = 2'd3; adc_sample = AW'(100); adc_valid = 1'b1;
    tick();
    adc_channel = 2'd0; adc_sample = AW'(200);
    tick();
    adc_valid = 1'b0;
    chk("tmo_issue_a", ma_data_in_1, ref_float(100));
    saw_valid = 1'b0;
    for (int k = 1; k <= 1023; k++) begin
      tick();
      saw_valid = saw_valid | corr_valid;
    end
    chk("tmo_not_yet", timeout_err, 0);
    chk("tmo_still_wait", state, 1);
    tick();
    saw_valid = saw_valid | corr_valid;
    chk("tmo_flag", timeout_err, 1);
    chk("tmo_idle", state, 0);
    chk("tmo_no_valid", saw_valid, 0);
    tick();
    chk("tmo_issue_b", ma_data_in_ready, 1);
    chk("tmo_b_data", ma_data_in_1, ref_float(200));
    chk("tmo_b_off", ma_data_in_3, m_off[0]);
    tick();
    pulse_result(32'hCAFE_F00D, 2'd0);

    // Reset during WAIT aborts the transaction and restores coefficients.
    write_coef(1'b0, 2'd0, 32'h4040_0000);
    adc_channel = 2'd0; adc_sample = AW'(5); adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    tick();
    chk("pre_rst_gain", ma_data_in_2, 32'h4040_0000);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    chk("mid_rst_in_1", ma_data_in_1, 0);
    chk("mid_rst_in_2", ma_data_in_2, 0);
    chk("mid_rst_in_3", ma_data_in_3, 0);
    chk("mid_rst_corr", corr_data, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_tmo", timeout_err, 0);
    chk("mid_rst_state", state, 0);
    ma_data_out = 32'h1234_5678; ma_data_out_ready = 1'b1;
    tick();
    ma_data_out_ready = 1'b0;
    chk("late_result_ignored", corr_valid, 0);
    chk("late_result_data", corr_data, 0);
    chk("late_result_state", state, 0);
    run_txn(2'd0, 7, ref_float(7), m_gain[0], m_off[0], 32'h0BAD_BEEF, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_sample_feeder.md
# adc_sample_feeder

Upstream stage of the floating-point gain/offset corrector (the multiply-adder). It accepts raw unsigned ADC samples tagged with a channel number and buffers them in a small FIFO. It converts each sample to IEEE-754 single precision and issues it, with that channel's gain and offset coefficients, as one multiply-add transaction. The multiply-adder is not pipelined, so this block holds one transaction in flight, waits for the result, and forwards it downstream with its channel tag.

## Interface
Parameters:
- ADC_WIDTH, 12, unsigned sample width; legal range 1..24, so conversion is always exact.
- FIFO_DEPTH, 4, sample FIFO entries; must be a power of two, at least 2.
- TIMEOUT, 1023, maximum cycles spent in WAIT before the transaction is abandoned.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-low; reset==0 at a posedge resets the block.
- adc_sample  in  ADC_WIDTH  raw unsigned sample.
- adc_channel  in  2  channel tag of adc_sample.
- adc_valid  in  1  sample strobe, sampled each posedge.
- coef_wr_en  in  1  coefficient write strobe.
- coef_sel  in  1  0 selects the gain register, 1 selects the offset register.
- coef_ch  in  2  channel whose coefficient is written.
- coef_data  in  32  IEEE-754 coefficient value.
- ma_data_in_1  out  32  converted sample (float).
- ma_data_in_2  out  32  gain[ch].
- ma_data_in_3  out  32  offset[ch].
- ma_data_in_ready  out  1  one-cycle issue pulse.
- ma_data_out  in  32  multiply-adder result.
- ma_data_out_ready  in  1  multiply-adder result strobe.
- corr_data  out  32  corrected result.
- corr_channel  out  2  channel tag of corr_data.
- corr_valid  out  1  one-cycle result pulse.
- fifo_full  out  1  FIFO count equals FIFO_DEPTH.
- overflow  out  1  sticky flag: a sample was dropped.
- timeout_err  out  1  sticky flag: a transaction was abandoned.
- state  out  2  FSM state, for debug.

## Operation
- **Reset.** All outputs go to 0 and the FIFO empties. gain[0..3] reset to 0x3F800000 (1.0). offset[0..3] reset to 0x00000000. The FSM goes to IDLE (0).
- **FIFO push.**
  - When adc_valid=1 and the FIFO is not full, {adc_channel, adc_sample} is written.
  - When adc_valid=1 and the FIFO is full, the sample is dropped and overflow is set to 1. This holds even if a pop occurs on the same edge.
  - Pointers wrap modulo FIFO_DEPTH.
- **Coefficient write.** On coef_wr_en=1, coef_data is written to gain[coef_ch] or offset[coef_ch]. The write takes effect at the next posedge. A coefficient written on the same edge as an issue is not used by that issue.
- **Int-to-float conversion.**
  - Sample 0 converts to 0x00000000.
  - Otherwise, let p be the index of the leading one. sign=0, exponent=127+p, and mantissa = (sample << (23-p)) with bits [22:0] kept.
  - No rounding is needed, because ADC_WIDTH ≤ 24.
- **FSM states.** IDLE=0, WAIT=1, DONE=2.
  - **IDLE, FIFO non-empty:**
    - Pop the head entry.
    - Register the converted sample, gain[ch] and offset[ch] onto ma_data_in_1/2/3.
    - Latch ch as the pending tag.
    - Assert ma_data_in_ready for exactly one cycle.
    - Clear the wait counter and go to WAIT.
  - **WAIT, ma_data_out_ready=1:**
    - corr_data ← ma_data_out, corr_channel ← pending tag, corr_valid ← 1.
    - Go to DONE.
  - **WAIT, counter = TIMEOUT:** set timeout_err to 1, drop the transaction and go to IDLE. corr_valid stays 0.
  - **WAIT, otherwise:** increment the counter.
  - **DONE:** clear corr_valid and go to IDLE, unconditionally.
- ma_data_out_ready is ignored in IDLE and DONE.
- ma_data_in_1/2/3 hold their values until the next issue.
- fifo_full is registered and reflects the count after each edge's push and pop.
- overflow and timeout_err clear only on reset.

## Timing
- **Issue latency.** adc_valid is sampled at edge E into an empty FIFO while the FSM is in IDLE. The FSM pops at edge E+1, and ma_data_in_ready is high during cycle E+1..E+2.
- **Result latency.** ma_data_out_ready is sampled high at edge R. corr_valid is high during cycle R..R+1, and the FSM is in DONE.
- **Next issue.** The earliest next issue is edge R+2. The minimum spacing between issues is therefore (multiply-adder latency + 3) cycles.
- **Sustained rate.** The FIFO absorbs bursts. Sustained input above one sample per issue spacing overflows.
- **Reset mid-transaction.** Reset at any edge aborts the in-flight transaction with no corr_valid. A ma_data_out_ready that arrives after reset is ignored, because the FSM is in IDLE.

## Test plan
- **Single-sample conversions.** Reset, then one sample at a time on ch0 with default coefficients, waiting for each result:
  - 1 → ma_data_in_1=0x3F800000.
  - 2048 → 0x45000000.
  - 4095 → 0x457FF000.
  - 0 → 0x00000000.
  - Each issue pulses ma_data_in_ready for exactly 1 cycle, at E+1.
- **Coefficients and result forwarding.**
  - Write gain[2]=0x40000000 and offset[2]=0x3F800000.
  - Send sample 3 on ch2 → ma_data_in_1=0x40400000, ma_data_in_2=0x40000000, ma_data_in_3=0x3F800000.
  - Return ma_data_out=0x40E00000 → corr_data=0x40E00000, corr_channel=2, corr_valid high for 1 cycle.
- **FIFO fill and overflow.** Stall ma_data_out_ready and send 6 consecutive samples (values 10..15).
  - One sample is issued and 4 are buffered; fifo_full=1.
  - The sixth sample is dropped and overflow=1.
  - After releasing results, outputs appear in order 10..14.
- **Timeout.** Hold ma_data_out_ready at 0 after an issue.
  - timeout_err=1 after TIMEOUT+1 WAIT cycles, with no corr_valid.
  - The next queued sample issues afterwards.
- **Reset mid-WAIT.**
  - Assert reset=0 for 1 cycle during WAIT, then pulse ma_data_out_ready.
  - Required: corr_valid stays 0, all outputs are 0, and gain[*] is back to 1.0.
